// File: rtl/add_share_sequencer.sv
// Round-robin sequencer that time-shares one 32-bit add/sub datapath between NREQ
// requesters. 64-bit ops take three passes: low word, high word, carry/borrow fix-up.

module add_share_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum,
  output logic        carry
);
  logic [32:0] full;

  // Subtraction is a + ~b + 1; the reported flag is borrow, i.e. inverted carry-out.
  assign full  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {32'b0, sub};
  assign sum   = full[31:0];
  assign carry = sub ? ~full[32] : full[32];
endmodule

module add_share_sequencer #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*64-1:0] req_a,
  input  logic [NREQ*64-1:0] req_b,
  input  logic [NREQ-1:0]    req_sub,
  input  logic [NREQ-1:0]    req_wide,
  output logic [NREQ-1:0]    gnt,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic [63:0]        resp_result,
  output logic               resp_carry,
  output logic               resp_overflow,
  output logic               resp_sign,
  output logic               resp_zero
);
  typedef enum logic [2:0] {IDLE, LO, HI, FIX, RESP} state_t;

  state_t         state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [63:0]    a_reg;
  logic [63:0]    b_reg;
  logic           sub_reg;
  logic           wide_reg;
  logic [31:0]    lo_reg;
  logic [31:0]    hi_reg;
  logic           c_lo_reg;
  logic           c_hi_reg;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [31:0]    op_a;
  logic [31:0]    op_b;
  logic [31:0]    add_sum;
  logic           add_carry;

  function automatic logic ovf(input logic a_msb, input logic b_msb,
                               input logic r_msb, input logic sub);
    return sub ? ((a_msb != b_msb) && (r_msb != a_msb))
               : ((a_msb == b_msb) && (r_msb != a_msb));
  endfunction

  // Search starts just after the last granted index, so the last winner ranks lowest.
  always_comb begin
    int k;
    grant_found = 1'b0;
    grant_idx   = '0;
    k           = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(ptr_reg) + i) % NREQ;
      if (!grant_found && req[k]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(k);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (rst_n && state_reg == IDLE && grant_found)
      gnt[grant_idx] = 1'b1;
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_reg)
      LO:      begin op_a = a_reg[31:0];  op_b = b_reg[31:0];        end
      HI:      begin op_a = a_reg[63:32]; op_b = b_reg[63:32];       end
      FIX:     begin op_a = hi_reg;       op_b = {31'b0, c_lo_reg};  end
      default: ;
    endcase
  end

  add_share_adder u_adder (
    .a     (op_a),
    .b     (op_b),
    .sub   (sub_reg),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= IDW'(NREQ - 1);
      a_reg         <= '0;
      b_reg         <= '0;
      sub_reg       <= 1'b0;
      wide_reg      <= 1'b0;
      lo_reg        <= '0;
      hi_reg        <= '0;
      c_lo_reg      <= 1'b0;
      c_hi_reg      <= 1'b0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_result   <= '0;
      resp_carry    <= 1'b0;
      resp_overflow <= 1'b0;
      resp_sign     <= 1'b0;
      resp_zero     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            a_reg     <= req_a[64*grant_idx +: 64];
            b_reg     <= req_b[64*grant_idx +: 64];
            sub_reg   <= req_sub[grant_idx];
            wide_reg  <= req_wide[grant_idx];
            ptr_reg   <= grant_idx;
            state_reg <= LO;
          end
        end
        LO: begin
          lo_reg   <= add_sum;
          c_lo_reg <= add_carry;
          if (wide_reg) begin
            state_reg <= HI;
          end else begin
            resp_result   <= {32'b0, add_sum};
            resp_carry    <= add_carry;
            resp_overflow <= ovf(a_reg[31], b_reg[31], add_sum[31], sub_reg);
            resp_sign     <= add_sum[31];
            resp_zero     <= (add_sum == 32'b0);
            resp_id       <= ptr_reg;
            resp_valid    <= 1'b1;
            state_reg     <= RESP;
          end
        end
        HI: begin
          hi_reg    <= add_sum;
          c_hi_reg  <= add_carry;
          state_reg <= FIX;
        end
        FIX: begin
          // The high word's own carry/borrow and the fix-up's can't both be set.
          resp_result   <= {add_sum, lo_reg};
          resp_carry    <= c_hi_reg | add_carry;
          resp_overflow <= ovf(a_reg[63], b_reg[63], add_sum[31], sub_reg);
          resp_sign     <= add_sum[31];
          resp_zero     <= ({add_sum, lo_reg} == 64'b0);
          resp_id       <= ptr_reg;
          resp_valid    <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_share_sequencer.sv
// Directed bench for add_share_sequencer: a scoreboard queue of expected responses is
// filled at grant time and drained by a response monitor on each handshake.

module tb_add_share_sequencer;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*64-1:0] req_a;
  logic [NREQ*64-1:0] req_b;
  logic [NREQ-1:0]    req_sub;
  logic [NREQ-1:0]    req_wide;
  logic [NREQ-1:0]    gnt;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [63:0]        resp_result;
  logic               resp_carry;
  logic               resp_overflow;
  logic               resp_sign;
  logic               resp_zero;

  add_share_sequencer #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_sub       (req_sub),
    .req_wide      (req_wide),
    .gnt           (gnt),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_result   (resp_result),
    .resp_carry    (resp_carry),
    .resp_overflow (resp_overflow),
    .resp_sign     (resp_sign),
    .resp_zero     (resp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    result;
    logic           carry;
    logic           ovf;
    logic           sign;
    logic           zero;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic exp_t model(input int id, input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, input logic wide);
    exp_t        e;
    logic [64:0] r65;
    logic [32:0] r33;
    int          n;
    e.id = IDW'(id);
    if (wide) begin
      r65      = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      e.result = r65[63:0];
      e.carry  = r65[64];
      n        = 63;
    end else begin
      r33      = sub ? ({1'b0, a[31:0]} - {1'b0, b[31:0]}) : ({1'b0, a[31:0]} + {1'b0, b[31:0]});
      e.result = {32'b0, r33[31:0]};
      e.carry  = r33[32];
      n        = 31;
    end
    e.sign = e.result[n];
    e.zero = wide ? (e.result == 64'b0) : (e.result[31:0] == 32'b0);
    e.ovf  = sub ? ((a[n] != b[n]) && (e.result[n] != a[n]))
                 : ((a[n] == b[n]) && (e.result[n] != a[n]));
    return e;
  endfunction

  // Response monitor: samples 2 time units after the falling edge, after stimulus settles.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'(resp_id), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        check("resp_id", 64'(resp_id), 64'(e.id));
        check("resp_result", resp_result, e.result);
        check("resp_flags", {60'b0, resp_carry, resp_overflow, resp_sign, resp_zero},
              {60'b0, e.carry, e.ovf, e.sign, e.zero});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic wait_gnt(output logic [NREQ-1:0] g);
    int n = 0;
    #1;
    while (gnt == '0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    g = gnt;
  endtask

  task automatic set_op(input int idx, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input logic wide);
    req_a[64*idx +: 64] = a;
    req_b[64*idx +: 64] = b;
    req_sub[idx]        = sub;
    req_wide[idx]       = wide;
  endtask

  task automatic run_op(input int idx, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input logic wide);
    logic [NREQ-1:0] g;
    int lat;
    @(negedge clk);
    req = '0;
    req[idx] = 1'b1;
    set_op(idx, a, b, sub, wide);
    wait_gnt(g);
    check("gnt", 64'(g), 64'(1 << idx));
    sb.push_back(model(idx, a, b, sub, wide));
    @(negedge clk);
    req[idx] = 1'b0;
    set_op(idx, {$urandom, $urandom}, {$urandom, $urandom}, ~sub, wide);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), wide ? 64'd4 : 64'd2);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [NREQ-1:0] g;
    logic [63:0]     snap;
    int              n;

    rst_n = 1'b0; req = '0; req_a = '0; req_b = '0;
    req_sub = '0; req_wide = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_outs", resp_result | 64'(resp_id), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    run_op(0, 64'h0000_0000_8000_0000, 64'd1, 1'b1, 1'b0);
    run_op(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    run_op(0, 64'd0, 64'd1, 1'b1, 1'b1);
    run_op(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    run_op(3, 64'h1234_5678_0000_0005, 64'h1234_5678_0000_0005, 1'b1, 1'b1);
    drain();

    // Stall in RESP with req1 pending: outputs hold and no grant until the handshake.
    @(negedge clk);
    resp_ready = 1'b0;
    req = 4'b0001;
    set_op(0, 64'h0000_0000_0000_1111, 64'h0000_0000_0000_2222, 1'b0, 1'b0);
    wait_gnt(g);
    check("stall_gnt0", 64'(g), 64'd1);
    sb.push_back(model(0, 64'h1111, 64'h2222, 1'b0, 1'b0));
    @(negedge clk);
    req = 4'b0010;
    set_op(1, 64'hAAAA_0000_0000_0007, 64'h0000_0000_0000_0003, 1'b1, 1'b1);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    snap = resp_result;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_nognt", 64'(gnt), 64'd0);
      check("stall_hold", {resp_result[62:0], resp_valid}, {snap[62:0], 1'b1});
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    check("hs_nognt", 64'(gnt), 64'd0);
    @(negedge clk); #1;
    check("gnt1_after_hs", 64'(gnt), 64'd2);
    sb.push_back(model(1, 64'hAAAA_0000_0000_0007, 64'd3, 1'b1, 1'b1));
    @(negedge clk);
    req = '0;
    drain();

    // Reset during HI of a wide op: response discarded, req0 first after release.
    @(negedge clk);
    req = 4'b0001;
    set_op(0, 64'h0F0F_0F0F_F0F0_F0F0, 64'h1111_1111_2222_2222, 1'b0, 1'b1);
    wait_gnt(g);
    check("pre_rst_gnt", 64'(g), 64'd1);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      set_op(i, 64'(i * 16 + 5), 64'(i + 1), 1'b0, 1'b0);
    req = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", resp_result, 64'd0);
    check("mid_rst_ctl", {62'b0, resp_valid, |gnt}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with all requests held.
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g);
      check("rr_gnt", 64'(g), 64'(1 << (k % NREQ)));
      sb.push_back(model(k % NREQ, 64'((k % NREQ) * 16 + 5), 64'((k % NREQ) + 1), 1'b0, 1'b0));
      @(negedge clk);
    end
    req = '0;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/add_share_sequencer.md
Name: add_share_sequencer

Overview:
- Shares one 32-bit add/sub datapath (internally instantiated) between NREQ requesters using round-robin arbitration.
- Runs 32-bit ops in one adder pass. Runs 64-bit ops as three passes: low word, high word, then a carry/borrow fix-up.
- Returns a registered result and flags over a valid/ready response channel.
- Sits between the ALU issue logic and the shared adder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the response id.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per requester; held until gnt, may be withdrawn before gnt.
- req_a  in  NREQ*64  operand A per requester; slice i = [64*i+63:64*i].
- req_b  in  NREQ*64  operand B per requester, same packing as req_a.
- req_sub  in  NREQ  1 = A-B, 0 = A+B.
- req_wide  in  NREQ  1 = 64-bit op, 0 = 32-bit op using low words only.
- gnt  out  NREQ  one-hot, one-cycle pulse; operands latched that cycle.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  IDW  index of the served requester.
- resp_result  out  64  result; [63:32]=0 for 32-bit ops.
- resp_carry  out  1  carry-out for add, borrow for sub.
- resp_overflow  out  1  two's-complement overflow.
- resp_sign  out  1  MSB of the result (bit 31 or bit 63).
- resp_zero  out  1  whole result width is zero.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt=0; resp_valid=0.
  - All resp_* outputs = 0.
  - Round-robin pointer = NREQ-1, so req0 has first priority.
  - Any in-flight operation is discarded and produces no response.
- FSM states: IDLE, LO, HI, FIX, RESP.
- IDLE:
  - If any req bit is set, grant the first set bit searching from pointer+1, wrapping modulo NREQ.
  - In the grant cycle: pulse gnt; latch A, B, sub, wide and id; set pointer = granted index; go to LO.
  - If no req bit is set, stay in IDLE.
- LO:
  - Adder computes A[31:0] op B[31:0]; capture the 32-bit result and c_lo.
  - Narrow op: set flags; go to RESP.
  - Wide op: go to HI.
- HI: adder computes A[63:32] op B[63:32]; capture the high result and c_hi.
- FIX:
  - Adder computes high op {31'b0, c_lo}: add +c_lo for add ops, subtract c_lo for sub ops.
  - Final carry = c_hi OR carry of the fix pass.
  - Go to RESP.
- RESP:
  - Hold resp_valid=1 with all resp_* outputs stable until resp_valid && resp_ready.
  - Then go to IDLE; no grant in the handshake cycle.
- Latency from the gnt cycle T: resp_valid rises at T+2 (narrow) or T+4 (wide), with resp_ready held high.
- Throughput: one narrow op per 3 cycles, one wide op per 5 cycles.
- Flags, with n = top bit of the active width (31 or 63):
  - overflow (add) = (A[n]==B[n]) && (R[n]!=A[n]).
  - overflow (sub) = (A[n]!=B[n]) && (R[n]!=A[n]).
  - sign = R[n].
  - zero = (R over the active width == 0).
- gnt is never asserted outside IDLE, and at most one bit is set at a time.
- A requester that withdraws req before gnt is simply skipped.
- Operand changes after gnt have no effect on the operation in flight.
- req asserted during LO/HI/FIX/RESP waits; arbitration happens only in IDLE, using the live req value.

Test Plan:
- Narrow add, req0, A=0xFFFFFFFF, B=1 -> gnt[0] at T; at T+2: result=0, carry=1, zero=1, overflow=0, sign=0, id=0.
- Narrow sub, A=0x80000000, B=1 -> result=0x7FFFFFFF, overflow=1, carry=0, sign=0.
- Wide add, A=0x00000000_FFFFFFFF, B=1 -> at T+4: result=0x00000001_00000000, carry=0, zero=0.
- Wide sub, A=0, B=1 -> result=0xFFFFFFFF_FFFFFFFF, carry=1, sign=1, overflow=0.
- All four req held continuously, resp_ready=1 -> gnt sequence 0,1,2,3,0, with responses in the same id order.
- Hold resp_ready=0 for 5 cycles in RESP with req1 pending -> outputs stable, no gnt; after the handshake, gnt[1] next cycle.
- Assert rst_n=0 during HI of a wide op -> outputs cleared immediately, no response for that op; req0 granted first after release.
